// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative 32x32 multiply/divide unit writing the HI/LO pair; stalls the front of the pipe while busy.
// Optional MULDIV_EARLY_EXIT_EN: multiply leaves CALC once the remaining multiplier bits are all zero.
module ex_muldiv_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] RSdata_i,
  input  logic [DATA_W-1:0] RTdata_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              div_zero_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned ACC_W = 2 * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   mcand;
  logic [DATA_W-1:0]  mplier;

  logic               a_neg_c;
  logic               b_neg_c;
  logic [DATA_W-1:0]  a_mag_c;
  logic [DATA_W-1:0]  b_mag_c;
  logic [DATA_W:0]    trial_c;
  logic [ACC_W-1:0]   mul_sum_c;
  logic [ACC_W-1:0]   prod_fix_c;
  logic [DATA_W-1:0]  q_fix_c;
  logic [DATA_W-1:0]  r_fix_c;
  logic               last_iter_c;

  // Operand magnitudes; only MULT/DIV (op_i[0]) treat operands as signed.
  always_comb begin
    a_neg_c = op_i[0] & RSdata_i[DATA_W-1];
    b_neg_c = op_i[0] & RTdata_i[DATA_W-1];
    a_mag_c = a_neg_c ? DATA_W'(-RSdata_i) : RSdata_i;
    b_mag_c = b_neg_c ? DATA_W'(-RTdata_i) : RTdata_i;
  end

  // Datapath: acc holds the product, or {remainder, shifting dividend/quotient} for divide.
  always_comb begin
    trial_c    = {acc[ACC_W-1:DATA_W], acc[DATA_W-1]} - {1'b0, mcand[DATA_W-1:0]};
    mul_sum_c  = acc + (mplier[0] ? mcand : '0);
    prod_fix_c = neg_q ? ACC_W'(-acc) : acc;
    r_fix_c    = neg_r ? DATA_W'(-acc[ACC_W-1:DATA_W]) : acc[ACC_W-1:DATA_W];
    q_fix_c    = neg_q ? DATA_W'(-acc[DATA_W-1:0]) : acc[DATA_W-1:0];
    // With a zero divisor the remainder path already yields the raw dividend.
    if (div_zero) q_fix_c = '1;
  end

  always_comb begin
    last_iter_c = (cnt == CNT_W'(DATA_W - 1));
`ifdef MULDIV_EARLY_EXIT_EN
    if (!is_div && (mplier[DATA_W-1:1] == '0)) last_iter_c = 1'b1;
`endif
  end

  // Stall is combinational in IDLE so the instruction is held in EX from its first cycle.
  assign stall_o = ((state == S_IDLE) && start_i) || (state == S_CALC) || (state == S_FIX);
  assign busy_o  = (state == S_CALC) || (state == S_FIX);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      is_div     <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_zero   <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      done_o     <= 1'b0;
      div_zero_o <= 1'b0;
      hi_o       <= '0;
      lo_o       <= '0;
    end else begin
      done_o     <= 1'b0;
      div_zero_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            state    <= S_CALC;
            is_div   <= op_i[1];
            neg_q    <= a_neg_c ^ b_neg_c;
            neg_r    <= a_neg_c;
            div_zero <= op_i[1] && (RTdata_i == '0);
            cnt      <= '0;
            mplier   <= b_mag_c;
            if (op_i[1]) begin
              acc   <= {{DATA_W{1'b0}}, a_mag_c};
              mcand <= {{DATA_W{1'b0}}, b_mag_c};
            end else begin
              acc   <= '0;
              mcand <= {{DATA_W{1'b0}}, a_mag_c};
            end
          end
        end
        S_CALC: begin
          if (flush_i) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (is_div) begin
              // Restoring step: keep the subtraction only when it does not borrow.
              if (!trial_c[DATA_W]) acc <= {trial_c[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
              else                  acc <= {acc[ACC_W-2:0], 1'b0};
            end else begin
              acc    <= mul_sum_c;
              mcand  <= {mcand[ACC_W-2:0], 1'b0};
              mplier <= {1'b0, mplier[DATA_W-1:1]};
            end
            if (last_iter_c) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (flush_i) begin
            state <= S_IDLE;
          end else begin
            state      <= S_DONE;
            done_o     <= 1'b1;
            div_zero_o <= div_zero;
            if (is_div) begin
              hi_o <= r_fix_c;
              lo_o <= q_fix_c;
            end else begin
              hi_o <= prod_fix_c[ACC_W-1:DATA_W];
              lo_o <= prod_fix_c[DATA_W-1:0];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed mul/div vectors, flush, reset, stall and latency.
// Honours MULDIV_EARLY_EXIT_EN when computing expected multiply latency.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          at;
  } exp_t;

  exp_t sb[$];

  ex_muldiv_unit dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .op_i       (op),
    .RSdata_i   (rs),
    .RTdata_i   (rt),
    .flush_i    (flush),
    .stall_o    (stall),
    .busy_o     (busy),
    .done_o     (done),
    .div_zero_o (div_zero),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected cycle offset of done_o after the start cycle.
  function automatic int lat(input logic [1:0] o, input logic [31:0] b);
    int n;
    logic [31:0] m;
    n = 32;
`ifdef MULDIV_EARLY_EXIT_EN
    if (!o[1]) begin
      m = (o[0] && b[31]) ? -b : b;
      n = 1;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    end
`endif
    return n + 2;
  endfunction

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
        chk("div_zero", 64'(div_zero), 64'(e.dz));
        chk("latency", 64'(cyc), 64'(e.at));
      end
    end else if (div_zero) begin
      chk("div_zero_without_done", 64'(div_zero), 64'(0));
    end
  end

  // Issue one op, hold start until the DONE cycle has passed, and check stall shape.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz);
    exp_t e;
    int   n = 0;
    int   stall_bad = 0;
    logic seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = o; rs = a; rt = b;
    e.hi = eh; e.lo = el; e.dz = edz; e.at = cyc + lat(o, b);
    sb.push_back(e);
    while (!seen && n < 100) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        if (stall !== 1'b0) stall_bad++;
      end else begin
        if (stall !== 1'b1) stall_bad++;
        @(posedge clk); #1;
        n++;
      end
    end
    chk("done_timeout", 64'(seen), 64'(1));
    chk("stall_shape", 64'(stall_bad), 64'(0));
    // start is still high across the DONE edge; the unit must not re-accept it.
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("idle_after_done", 64'(busy), 64'(0));
  endtask

  initial begin
    logic [31:0] ph;
    logic [31:0] pl;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs = '0; rt = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_stall", 64'(stall), 64'(0));

    do_op(2'b00, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    do_op(2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
    do_op(2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    do_op(2'b00, 32'd5,         32'd3,         32'd0,         32'd15,        1'b0);
    do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    do_op(2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);
    do_op(2'b11, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    do_op(2'b00, 32'h1234_5678, 32'd0,         32'd0,         32'd0,         1'b0);
    do_op(2'b10, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0);

    // Flush in CALC cycle 10: back to IDLE, no result, HI/LO untouched.
    ph = hi; pl = lo;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; rs = 32'h0000_1234; rt = 32'hFFFF_FFFF;
    repeat (10) begin @(posedge clk); #1; end
    start = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(busy), 64'(0));
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("flush_hi", 64'(hi), 64'(ph));
    chk("flush_lo", 64'(lo), 64'(pl));

    // flush beats start in IDLE.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = 2'b10; rs = 32'd9; rt = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_beats_start", 64'(busy), 64'(0));

    // Reset mid-CALC clears HI/LO and returns to IDLE.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; rs = 32'd11; rt = 32'hFFFF_0000;
    repeat (5) begin @(posedge clk); #1; end
    start = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_hi", 64'(hi), 64'(0));
    chk("midrst_lo", 64'(lo), 64'(0));
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("midrst_no_done_hi", 64'(hi), 64'(0));

    // Back to normal operation after the mid-op reset.
    do_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
